vscale_htif_pcr_host: RTL and testbench

- Host-side HTIF PCR requester; drives the core's htif_pcr_req_* channel and consumes htif_pcr_resp_*. Replaces the constant tie-offs used at top level today.
- Converts a simple command/response port (testbench or debug bridge) into single outstanding PCR read/write transactions.
- Includes a response timeout and an optional tohost polling engine.

---
 rtl/vscale_htif_pcr_host.sv | 220 ++++++++++++++++++++++
 tb/tb_vscale_htif_pcr_host.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vscale_htif_pcr_host.sv
// Host-side HTIF PCR requester: turns a cmd/rsp port into single outstanding PCR
// transactions with a response timeout. Optional tohost poller: HTIF_TOHOST_POLL_EN.
module vscale_htif_pcr_host #(
  parameter int unsigned           ADDR_WIDTH     = 12,
  parameter int unsigned           DATA_WIDTH     = 64,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter int unsigned           POLL_INTERVAL  = 256,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(12'h780)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  htif_pcr_req_valid,
  input  logic                  htif_pcr_req_ready,
  output logic                  htif_pcr_req_rw,
  output logic [ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [DATA_WIDTH-1:0] htif_pcr_req_data,
  input  logic                  htif_pcr_resp_valid,
  output logic                  htif_pcr_resp_ready,
  input  logic [DATA_WIDTH-1:0] htif_pcr_resp_data
`ifdef HTIF_TOHOST_POLL_EN
  ,
  output logic                  tohost_valid,
  output logic [DATA_WIDTH-1:0] tohost_data
`endif
);

  localparam int unsigned TCNT_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  timeout_hit;
  logic                  do_abort;
  logic                  do_done;

`ifdef HTIF_TOHOST_POLL_EN
  localparam int unsigned       PCNT_W    = 16;
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_INTERVAL - 1);

  localparam logic [1:0] KIND_CMD     = 2'd0;
  localparam logic [1:0] KIND_POLL_RD = 2'd1;
  localparam logic [1:0] KIND_POLL_WR = 2'd2;

  logic [1:0]            kind_q, kind_d;
  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic                  tohost_valid_q, tohost_valid_d;
  logic [DATA_WIDTH-1:0] tohost_data_q, tohost_data_d;
`else
  logic unused_poll_cfg;
  assign unused_poll_cfg = ^{POLL_INTERVAL, TOHOST_ADDR};
`endif

  // Completion is checked before timeout so a response on the last cycle still wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and datapath register update.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tcnt_d   = tcnt_q;
    do_abort = 1'b0;
    do_done  = 1'b0;
`ifdef HTIF_TOHOST_POLL_EN
    kind_d         = kind_q;
    pcnt_d         = pcnt_q;
    tohost_valid_d = 1'b0;
    tohost_data_d  = tohost_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
`ifdef HTIF_TOHOST_POLL_EN
        if (pcnt_q != POLL_LAST) pcnt_d = pcnt_q + PCNT_W'(1);
`endif
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          tcnt_d  = '0;
          state_d = ST_REQ;
`ifdef HTIF_TOHOST_POLL_EN
          kind_d  = KIND_CMD;
        end else if (pcnt_q == POLL_LAST) begin
          rw_d    = 1'b0;
          addr_d  = TOHOST_ADDR;
          wdata_d = '0;
          tcnt_d  = '0;
          kind_d  = KIND_POLL_RD;
          pcnt_d  = '0;
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (timeout_hit)             do_abort = 1'b1;
        else if (htif_pcr_req_ready) state_d  = ST_RESP;
      end
      ST_RESP: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        if (htif_pcr_resp_valid) do_done  = 1'b1;
        else if (timeout_hit)    do_abort = 1'b1;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_abort) begin
`ifdef HTIF_TOHOST_POLL_EN
      if (kind_q != KIND_CMD) state_d = ST_IDLE;
      else
`endif
      begin
        state_d = ST_DONE;
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end

    if (do_done) begin
`ifdef HTIF_TOHOST_POLL_EN
      // Nonzero tohost: report it, then clear it with a write whose response is dropped.
      if (kind_q == KIND_POLL_RD) begin
        if (htif_pcr_resp_data != '0) begin
          tohost_valid_d = 1'b1;
          tohost_data_d  = htif_pcr_resp_data;
          rw_d           = 1'b1;
          addr_d         = TOHOST_ADDR;
          wdata_d        = '0;
          kind_d         = KIND_POLL_WR;
          tcnt_d         = '0;
          state_d        = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end else if (kind_q == KIND_POLL_WR) state_d = ST_IDLE;
      else
`endif
      begin
        state_d = ST_DONE;
        err_d   = 1'b0;
        rdata_d = htif_pcr_resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
`ifdef HTIF_TOHOST_POLL_EN
      kind_q         <= KIND_CMD;
      pcnt_q         <= '0;
      tohost_valid_q <= 1'b0;
      tohost_data_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
`ifdef HTIF_TOHOST_POLL_EN
      kind_q         <= kind_d;
      pcnt_q         <= pcnt_d;
      tohost_valid_q <= tohost_valid_d;
      tohost_data_q  <= tohost_data_d;
`endif
    end
  end

  // Handshake outputs decode the state register only.
  assign cmd_ready           = (state_q == ST_IDLE);
  assign htif_pcr_req_valid  = (state_q == ST_REQ);
  assign htif_pcr_resp_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
  assign rsp_valid           = (state_q == ST_DONE);
  assign rsp_rdata           = rdata_q;
  assign rsp_err             = err_q;
  assign htif_pcr_req_rw     = rw_q;
  assign htif_pcr_req_addr   = addr_q;
  assign htif_pcr_req_data   = wdata_q;

`ifdef HTIF_TOHOST_POLL_EN
  assign tohost_valid = tohost_valid_q;
  assign tohost_data  = tohost_data_q;
`endif

endmodule

// File: tb/tb_vscale_htif_pcr_host.sv
// Directed + randomized bench for vscale_htif_pcr_host with an 8-cycle timeout.
module tb_vscale_htif_pcr_host;

  localparam int unsigned AW  = 12;
  localparam int unsigned DW  = 64;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_rw;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          req_valid, req_ready, req_rw;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
`ifdef HTIF_TOHOST_POLL_EN
  logic          tohost_valid;
  logic [DW-1:0] tohost_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vscale_htif_pcr_host #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TMO),
    .POLL_INTERVAL (65535)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_rw             (cmd_rw),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .htif_pcr_req_valid (req_valid),
    .htif_pcr_req_ready (req_ready),
    .htif_pcr_req_rw    (req_rw),
    .htif_pcr_req_addr  (req_addr),
    .htif_pcr_req_data  (req_data),
    .htif_pcr_resp_valid(resp_valid),
    .htif_pcr_resp_ready(resp_ready),
    .htif_pcr_resp_data (resp_data)
`ifdef HTIF_TOHOST_POLL_EN
    ,
    .tohost_valid       (tohost_valid),
    .tohost_data        (tohost_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {cmd_ready, rsp_valid, req_valid, resp_ready}
  function automatic logic [63:0] flags();
    return 64'({cmd_ready, rsp_valid, req_valid, resp_ready});
  endfunction

  // One transaction. The core holds req_ready low for dr REQ cycles, then returns
  // its response dv cycles into RESP; the host holds rsp_ready low for drsp cycles.
  // Model: the transaction succeeds iff its completion cycle (counted from REQ
  // entry) is no later than TMO-1; otherwise the error response appears at TMO.
  task automatic do_txn(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input int dr, input int dv, input int drsp,
                        input logic [DW-1:0] core_data);
    int            done_t;
    int            lat;
    bit            ok;
    logic [DW-1:0] exp_data;
    done_t   = dr + dv + 1;
    ok       = done_t <= int'(TMO) - 1;
    lat      = ok ? done_t + 1 : int'(TMO);
    exp_data = ok ? core_data : '0;

    chk("idle_flags", flags(), 64'h9);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0;
    cmd_rw    = ~rw;
    cmd_addr  = AW'($urandom);
    cmd_wdata = {$urandom, $urandom};

    for (int t = 0; t <= lat + drsp; t++) begin
      req_ready  = (t >= dr);
      resp_valid = (t == done_t);
      resp_data  = (t == done_t) ? core_data : {$urandom, $urandom};
      rsp_ready  = (t == lat + drsp);
      if (t < lat) begin
        chk("busy_flags", flags(), 64'({2'b00, t <= dr, t > dr}));
        if (t <= dr) begin
          chk("req_rw", 64'(req_rw), 64'(rw));
          chk("req_addr", 64'(req_addr), 64'(a));
          chk("req_data", req_data, wd);
        end
      end else begin
        chk("done_flags", flags(), 64'h4);
        chk("rsp_err", 64'(rsp_err), 64'(!ok));
        chk("rsp_rdata", rsp_rdata, exp_data);
      end
      tick();
    end
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    rsp_ready  = 1'b0;
    chk("after_ack_flags", flags(), 64'h9);
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_rw     = 1'b0;
    cmd_addr   = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    tick();
    tick();

    chk("reset_flags", flags(), 64'h9);
    chk("reset_rsp_rdata", rsp_rdata, 64'h0);
    chk("reset_rsp_err", 64'(rsp_err), 64'h0);
    chk("reset_req_addr", 64'(req_addr), 64'h0);
    chk("reset_req_data", req_data, 64'h0);
    chk("reset_req_rw", 64'(req_rw), 64'h0);
    reset = 1'b0;
    tick();

    // Minimum-latency write.
    do_txn(1'b1, 12'h781, 64'hDEAD_BEEF, 0, 0, 0, 64'h55);
    // Backpressure read finishing on the last allowed cycle (completion beats timeout).
    do_txn(1'b0, 12'h300, 64'h0, 5, 1, 3, 64'h1234);
    // One cycle later: timeout inside RESP.
    do_txn(1'b0, 12'h301, 64'h0, 5, 2, 1, 64'h9999);
    // Timeout while still in REQ.
    do_txn(1'b1, 12'h302, 64'hABCD, 12, 0, 0, 64'h7777);
    // No response at all.
    do_txn(1'b0, 12'h303, 64'h0, 0, 40, 2, 64'h1);

    // A late response while idle is drained without producing a rsp.
    resp_valid = 1'b1;
    resp_data  = 64'hBAD;
    chk("late_resp_drain", flags(), 64'h9);
    tick();
    resp_valid = 1'b0;
    chk("late_resp_no_rsp", flags(), 64'h9);
    tick();
    chk("late_resp_still_idle", flags(), 64'h9);

    // Reset while waiting in RESP abandons the transaction.
    cmd_valid = 1'b1;
    cmd_rw    = 1'b0;
    cmd_addr  = 12'h123;
    tick();
    cmd_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    chk("pre_reset_in_resp", flags(), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_reset_flags", flags(), 64'h9);
    tick();
    chk("post_reset_idle", flags(), 64'h9);
    do_txn(1'b0, 12'h124, 64'h0, 1, 1, 0, 64'hFEED_F00D);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom), AW'($urandom), {$urandom, $urandom},
             int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
             int'($urandom_range(0, 3)), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
